// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct
// codes, datapath select encodings, FSM state codes and instruction classes.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_LUI  = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  typedef enum logic [3:0] {
    CL_NOP, CL_ADDU, CL_SUBU, CL_ORI, CL_LUI,
    CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL
  } ins_class_t;

  // Classes whose EXEC cycle is also their last cycle.
  function automatic logic exec_is_final(input ins_class_t cls);
    return (cls == CL_NOP) || (cls == CL_BEQ) || (cls == CL_J) || (cls == CL_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational classifier: instruction register -> instruction class
// plus a legal bit. Anything outside the supported set is flagged illegal.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output ins_class_t  ins_class,
  output logic        legal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  always_comb begin
    ins_class = CL_NOP;
    legal     = 1'b1;
    // The all-zero word is nop; other R-type encodings only count for addu/subu.
    if (ir == 32'h0000_0000) begin
      ins_class = CL_NOP;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU: ins_class = CL_ADDU;
            FN_SUBU: ins_class = CL_SUBU;
            default: legal = 1'b0;
          endcase
        end
        OP_ORI:  ins_class = CL_ORI;
        OP_LUI:  ins_class = CL_LUI;
        OP_LW:   ins_class = CL_LW;
        OP_SW:   ins_class = CL_SW;
        OP_BEQ:  ins_class = CL_BEQ;
        OP_J:    ins_class = CL_J;
        OP_JAL:  ins_class = CL_JAL;
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: latches the fetched word, sequences each
// instruction through its states and drives Moore datapath/PC controls.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_ctrl,
  input  logic [31:0]      im_out_ins,
  output logic             pc_we,
  output logic             npc_sel,
  output logic             isJump,
  output logic [15:0]      npc_in_imm16,
  output logic [25:0]      npc_in_imm26,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic             ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [31:0]      ir_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] retired_reg;
  ins_class_t       ins_class;
  logic             legal;
  logic             final_cycle;
  logic             exec_phase;

  ctrl_decode u_decode (
    .ir        (ir_reg),
    .ins_class (ins_class),
    .legal     (legal)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (exec_is_final(ins_class))
          state_next = S_FETCH;
        else if (ins_class == CL_LW || ins_class == CL_SW)
          state_next = S_MEM;
        else
          state_next = S_WB;
      end
      S_MEM:    state_next = (ins_class == CL_SW) ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      state_reg   <= S_FETCH;
      ir_reg      <= 32'h0000_0000;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH)
        ir_reg <= im_out_ins;
      if (state_reg == S_DECODE && !legal)
        illegal_reg <= 1'b1;
      if (final_cycle)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign exec_phase = (state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB);

  always_comb begin
    final_cycle = 1'b0;
    npc_sel     = 1'b0;
    isJump      = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = DST_RT;
    wb_sel      = WB_ALU;
    alu_src     = 1'b0;
    ext_op      = 1'b0;
    alu_op      = ALU_ADD;
    mem_we      = 1'b0;

    // Datapath selects are a function of ir alone once execution has begun.
    if (exec_phase) begin
      case (ins_class)
        CL_ADDU: reg_dst = DST_RD;
        CL_SUBU: begin reg_dst = DST_RD; alu_op = ALU_SUB; end
        CL_ORI:  begin alu_src = 1'b1; alu_op = ALU_OR; end
        CL_LUI:  begin alu_src = 1'b1; alu_op = ALU_LUI; end
        CL_LW:   begin alu_src = 1'b1; ext_op = 1'b1; wb_sel = WB_MEM; end
        CL_SW:   begin alu_src = 1'b1; ext_op = 1'b1; end
        CL_BEQ:  begin ext_op = 1'b1; alu_op = ALU_SUB; end
        CL_JAL:  begin reg_dst = DST_RA; wb_sel = WB_PC4; end
        default: ;
      endcase
    end

    case (state_reg)
      S_EXEC: begin
        if (exec_is_final(ins_class)) begin
          final_cycle = 1'b1;
          npc_sel     = (ins_class == CL_BEQ);
          isJump      = (ins_class == CL_J) || (ins_class == CL_JAL);
          reg_we      = (ins_class == CL_JAL);
        end
      end
      S_MEM: begin
        if (ins_class == CL_SW) begin
          mem_we      = 1'b1;
          final_cycle = 1'b1;
        end
      end
      S_WB: begin
        reg_we      = 1'b1;
        final_cycle = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_we        = final_cycle;
  assign npc_in_imm16 = ir_reg[15:0];
  assign npc_in_imm26 = ir_reg[25:0];
  assign illegal      = illegal_reg;
  assign retired      = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// supported instruction plus trap, mid-instruction reset and counter wrap.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_ctrl;
  logic [31:0]   im_out_ins;
  logic          pc_we, npc_sel, isJump, reg_we, alu_src, ext_op, mem_we, illegal;
  logic [15:0]   npc_in_imm16;
  logic [25:0]   npc_in_imm26;
  logic [1:0]    reg_dst, wb_sel, alu_op;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_ctrl(rst_ctrl), .im_out_ins(im_out_ins),
    .pc_we(pc_we), .npc_sel(npc_sel), .isJump(isJump),
    .npc_in_imm16(npc_in_imm16), .npc_in_imm26(npc_in_imm26),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op),
    .mem_we(mem_we), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle order: pc_we npc_sel isJump reg_we reg_dst wb_sel alu_src ext_op alu_op mem_we
  function automatic logic [12:0] mk(input logic pc, input logic ns, input logic jp,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                                     input logic as, input logic ex, input logic [1:0] ao,
                                     input logic mw);
    return {pc, ns, jp, rw, rd, wb, as, ex, ao, mw};
  endfunction

  function automatic logic [12:0] bundle();
    return {pc_we, npc_sel, isJump, reg_we, reg_dst, wb_sel, alu_src, ext_op, alu_op, mem_we};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          ncyc;
    logic [12:0] exp [5];
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Entered at a falling edge while the DUT sits in S_FETCH; leaves at the
  // falling edge of the following S_FETCH.
  task automatic run_vec(input vec_t v);
    im_out_ins = v.ins;
    for (int c = 0; c < v.ncyc; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("%s.cyc%0d", v.name, c), 32'(bundle()), 32'(v.exp[c]));
      if (c == 2) begin
        check($sformatf("%s.imm16", v.name), 32'(npc_in_imm16), 32'(v.ins[15:0]));
        check($sformatf("%s.imm26", v.name), 32'(npc_in_imm26), 32'(v.ins[25:0]));
      end
    end
    @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << CW);
    check($sformatf("%s.next_fetch", v.name), 32'(bundle()), 32'h0);
    check($sformatf("%s.retired", v.name), 32'(retired), 32'(exp_ret));
    check($sformatf("%s.illegal", v.name), 32'(illegal), 32'h0);
    $display("ins %s 0x%08h cycles=%0d retired=%0d", v.name, v.ins, v.ncyc, retired);
  endtask

  initial begin
    logic [12:0] z;
    logic [12:0] lw_mem;
    z = 13'h0;
    vecs[0] = '{"addu", 32'h00221821, 4, '{z, z, mk(0,0,0,0,1,0,0,0,0,0), mk(1,0,0,1,1,0,0,0,0,0), z}};
    vecs[1] = '{"subu", 32'h00221823, 4, '{z, z, mk(0,0,0,0,1,0,0,0,1,0), mk(1,0,0,1,1,0,0,0,1,0), z}};
    vecs[2] = '{"ori",  32'h34021234, 4, '{z, z, mk(0,0,0,0,0,0,1,0,2,0), mk(1,0,0,1,0,0,1,0,2,0), z}};
    vecs[3] = '{"lui",  32'h3C011234, 4, '{z, z, mk(0,0,0,0,0,0,1,0,3,0), mk(1,0,0,1,0,0,1,0,3,0), z}};
    vecs[4] = '{"lw",   32'h8C040008, 5, '{z, z, mk(0,0,0,0,0,1,1,1,0,0), mk(0,0,0,0,0,1,1,1,0,0),
                                           mk(1,0,0,1,0,1,1,1,0,0)}};
    vecs[5] = '{"sw",   32'hAC040008, 4, '{z, z, mk(0,0,0,0,0,0,1,1,0,0), mk(1,0,0,0,0,0,1,1,0,1), z}};
    vecs[6] = '{"beq",  32'h10220003, 3, '{z, z, mk(1,1,0,0,0,0,0,1,1,0), z, z}};
    vecs[7] = '{"j",    32'h08000010, 3, '{z, z, mk(1,0,1,0,0,0,0,0,0,0), z, z}};
    vecs[8] = '{"jal",  32'h0C000010, 3, '{z, z, mk(1,0,1,1,2,2,0,0,0,0), z, z}};
    vecs[9] = '{"nop",  32'h00000000, 3, '{z, z, mk(1,0,0,0,0,0,0,0,0,0), z, z}};
    lw_mem = mk(0,0,0,0,0,1,1,1,0,0);

    rst_ctrl   = 1'b1;
    im_out_ins = 32'h0;
    repeat (3) @(negedge clk);
    rst_ctrl = 1'b0;
    check("reset.bundle", 32'(bundle()), 32'h0);
    check("reset.retired", 32'(retired), 32'h0);
    check("reset.illegal", 32'(illegal), 32'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Unsupported opcode: trap after decode, no PC activity, input ignored.
    im_out_ins = 32'hFC000000;
    check("trap.fetch", 32'(bundle()), 32'h0);
    @(negedge clk);
    im_out_ins = 32'h00000000;
    check("trap.decode", 32'(bundle()), 32'h0);
    check("trap.decode_illegal", 32'(illegal), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("trap.idle%0d", i), 32'({bundle(), illegal}), 32'h1);
    end
    check("trap.retired", 32'(retired), 32'(exp_ret));
    $display("ins trap 0xFC000000 illegal=%0d retired=%0d", illegal, retired);
    rst_ctrl = 1'b1;
    #1;
    check("trap.rst_illegal", 32'(illegal), 32'h0);
    check("trap.rst_retired", 32'(retired), 32'h0);
    @(negedge clk);
    rst_ctrl = 1'b0;
    exp_ret = 0;
    run_vec(vecs[0]);

    // Reset during lw S_MEM aborts the instruction without a clock edge.
    im_out_ins = vecs[4].ins;
    repeat (3) @(negedge clk);
    check("abort.mem_state", 32'(bundle()), 32'(lw_mem));
    #1 rst_ctrl = 1'b1;
    #1;
    check("abort.bundle", 32'(bundle()), 32'h0);
    check("abort.retired", 32'(retired), 32'h0);
    check("abort.imm16", 32'(npc_in_imm16), 32'h0);
    @(negedge clk);
    rst_ctrl = 1'b0;
    exp_ret = 0;
    $display("ins lw aborted by reset retired=%0d", retired);
    run_vec(vecs[0]);

    // Fill the counter to all-ones, then wrap it and keep running.
    for (int i = 0; i < (1 << CW) - 2; i++) run_vec(vecs[9]);
    check("wrap.full", 32'(retired), 32'((1 << CW) - 1));
    run_vec(vecs[9]);
    check("wrap.zero", 32'(retired), 32'h0);
    run_vec(vecs[0]);
    run_vec(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
